// File: rtl/fir_avg_sched_pkg.sv
// fir_avg_sched_pkg
// Shared types and constants for the time-multiplexed 4-tap averaging
// scheduler: FSM state encoding, datapath widths, the Q8 scale shift and a
// ceiling-log2 helper used to size the round-robin pointer and channel tags.
package fir_avg_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int COEF_DEF = 64;
  localparam int ACC_W    = 32;
  localparam int DIN_W    = 16;
  localparam int DOUT_W   = 24;
  localparam int SHIFT    = 8;

  // Returns at least 1 so that a 2-entry pointer still gets a real bit.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/fir_rr_arbiter.sv
// fir_rr_arbiter
// Combinational round-robin arbiter. Grants the first requesting channel at
// or after the pointer, wrapping modulo N_CH.
// Ports:
//   req     in  N_CH   request vector
//   ptr     in  PTR_W  highest-priority channel this cycle
//   gnt     out N_CH   one-hot grant (all zero when no request)
//   gnt_idx out PTR_W  encoded index of the granted channel
//   gnt_any out 1      any request granted
module fir_rr_arbiter #(
  parameter int N_CH  = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_CH-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_CH-1:0]  gnt,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             gnt_any
);

  always_comb begin
    logic [PTR_W-1:0] c;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    c       = '0;
    for (int off = 0; off < N_CH; off++) begin
      c = PTR_W'((int'(ptr) + off) % N_CH);
      if (!gnt_any && req[c]) begin
        gnt_any = 1'b1;
        gnt[c]  = 1'b1;
        gnt_idx = c;
      end
    end
  end

endmodule

// File: rtl/fir_avg_sched.sv
// fir_avg_sched
// Shares one averaging MAC between N_CH channels. Samples are taken
// round-robin, each is multiplied against the channel's own tap history one
// tap per cycle, and the Q8-scaled result is returned with its channel tag.
// Ports:
//   clk        in  1            rising-edge clock
//   rst        in  1            synchronous active-high reset
//   in_valid   in  N_CH         per-channel sample valid
//   in_data    in  DATA_W*N_CH  signed samples, channel k at [DATA_W*k +: DATA_W]
//   in_ready   out N_CH         one-hot grant, only ever high in IDLE
//   out_valid  out 1            result valid
//   out_data   out 24           signed averaged result
//   out_chan   out 3            channel of out_data
//   out_ready  in  1            downstream accept
//   busy       out 1            FSM not in IDLE
// Build option: define FIR_AVG_SCHED_ROUND_EN to round half up instead of
// truncating (floor) when scaling the accumulator down to out_data.
module fir_avg_sched
  import fir_avg_sched_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int TAPS   = 4,
  parameter int COEF   = COEF_DEF,
  parameter int DATA_W = DIN_W,
  parameter int COEF_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          in_valid,
  input  logic [DATA_W*N_CH-1:0]   in_data,
  output logic [N_CH-1:0]          in_ready,
  output logic                     out_valid,
  output logic signed [DOUT_W-1:0] out_data,
  output logic [2:0]               out_chan,
  input  logic                     out_ready,
  output logic                     busy
);

  localparam int PTR_W = clog2(N_CH);
  localparam int TAP_W = clog2(TAPS);
  localparam logic signed [COEF_W-1:0] COEF_S = COEF_W'(COEF);

  // Scale the Q8 accumulator down to the output width.
  function automatic logic signed [DOUT_W-1:0] scale_out(input logic signed [ACC_W-1:0] a);
`ifdef FIR_AVG_SCHED_ROUND_EN
    return DOUT_W'((a + 32'sd128) >>> SHIFT);
`else
    return DOUT_W'(a >>> SHIFT);
`endif
  endfunction

  state_t                     state_q, state_d;
  logic [PTR_W-1:0]           rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]           ch_q, ch_d;
  logic [TAP_W-1:0]           tap_q, tap_d;
  logic signed [DATA_W-1:0]   sample_q, sample_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [DATA_W-1:0]   hist_q [N_CH][TAPS-1];
  logic signed [DATA_W-1:0]   hist_d [N_CH][TAPS-1];
  logic                       out_valid_q, out_valid_d;
  logic signed [DOUT_W-1:0]   out_data_q, out_data_d;
  logic [2:0]                 out_chan_q, out_chan_d;

  logic signed [DATA_W-1:0]   din [N_CH];
  logic signed [DATA_W-1:0]   tap_line [TAPS];
  logic signed [DATA_W-1:0]   tap_x;
  logic signed [ACC_W-1:0]    prod;
  logic [N_CH-1:0]            gnt;
  logic [PTR_W-1:0]           gnt_idx;
  logic                       gnt_any;

  fir_rr_arbiter #(
    .N_CH  (N_CH),
    .PTR_W (PTR_W)
  ) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_comb begin
    for (int k = 0; k < N_CH; k++) din[k] = in_data[DATA_W*k +: DATA_W];
  end

  // Tap select: tap 0 is the fresh sample, tap i is history[i-1] (newest first)
  always_comb begin
    tap_line[0] = sample_q;
    for (int i = 1; i < TAPS; i++) tap_line[i] = hist_q[ch_q][i-1];
    tap_x = tap_line[tap_q];
    prod  = ACC_W'(tap_x) * ACC_W'(COEF_S);
  end

  assign in_ready  = (state_q == IDLE && !rst) ? gnt : '0;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    ch_d        = ch_q;
    tap_d       = tap_q;
    sample_d    = sample_q;
    acc_d       = acc_q;
    hist_d      = hist_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          ch_d     = gnt_idx;
          sample_d = din[gnt_idx];
          acc_d    = '0;
          tap_d    = '0;
          state_d  = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + prod;
        tap_d = tap_q + 1'b1;
        if (tap_q == TAP_W'(TAPS-1)) begin
          // Last tap: retire the sample into history, oldest falls off
          for (int i = TAPS-2; i > 0; i--) hist_d[ch_q][i] = hist_q[ch_q][i-1];
          hist_d[ch_q][0] = sample_q;
          tap_d       = '0;
          out_data_d  = scale_out(acc_d);
          out_chan_d  = 3'(ch_q);
          out_valid_d = 1'b1;
          state_d     = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          rr_ptr_d    = (ch_q == PTR_W'(N_CH-1)) ? '0 : ch_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      ch_q        <= '0;
      tap_q       <= '0;
      sample_q    <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      for (int c = 0; c < N_CH; c++)
        for (int i = 0; i < TAPS-1; i++) hist_q[c][i] <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      ch_q        <= ch_d;
      tap_q       <= tap_d;
      sample_q    <= sample_d;
      acc_q       <= acc_d;
      hist_q      <= hist_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
    end
  end

endmodule

// File: tb/tb_fir_avg_sched.sv
module tb_fir_avg_sched;

  localparam int N_CH = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [N_CH-1:0]        in_valid = '0;
  logic [16*N_CH-1:0]     in_data = '0;
  logic [N_CH-1:0]        in_ready;
  logic                   out_valid;
  logic signed [23:0]     out_data;
  logic [2:0]             out_chan;
  logic                   out_ready = 1'b0;
  logic                   busy;

  fir_avg_sched dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int multi_gnt = 0;

  typedef struct {
    int          data;
    logic [23:0] raw;
    int          chan;
    int          cyc;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];
  int   gnt_ch_q[$];
  int   gnt_cyc_q[$];
  int   hist_m [N_CH][3];

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: 4-tap average, coefficient 64, Q8 output
  function automatic int model_accept(input int c, input int x);
    int sum;
    sum = x + hist_m[c][0] + hist_m[c][1] + hist_m[c][2];
    hist_m[c][2] = hist_m[c][1];
    hist_m[c][1] = hist_m[c][0];
    hist_m[c][0] = x;
`ifdef FIR_AVG_SCHED_ROUND_EN
    return (sum * 64 + 128) >>> 8;
`else
    return (sum * 64) >>> 8;
`endif
  endfunction

  task automatic clear_model();
    for (int c = 0; c < N_CH; c++)
      for (int i = 0; i < 3; i++) hist_m[c][i] = 0;
    exp_q.delete();
    obs_q.delete();
    gnt_ch_q.delete();
    gnt_cyc_q.delete();
  endtask

  // Scoreboard feed: expected pushed on every accept, observed on every output handshake
  always @(negedge clk) begin
    rec_t r;
    if (!rst) begin
      if ($countones(in_ready) > 1) multi_gnt++;
      for (int k = 0; k < N_CH; k++) begin
        if (in_valid[k] && in_ready[k]) begin
          r.data = model_accept(k, int'($signed(in_data[16*k +: 16])));
          r.raw  = 24'(r.data);
          r.chan = k;
          r.cyc  = cyc;
          exp_q.push_back(r);
          gnt_ch_q.push_back(k);
          gnt_cyc_q.push_back(cyc);
        end
      end
      if (out_valid && out_ready) begin
        r.data = int'(out_data);
        r.raw  = out_data;
        r.chan = int'(out_chan);
        r.cyc  = cyc;
        obs_q.push_back(r);
      end
    end
  end

  task automatic send(input int c, input int val, output bit ok);
    int budget;
    @(posedge clk); #1;
    in_valid[c] = 1'b1;
    in_data[16*c +: 16] = 16'(val);
    ok = 1'b0;
    budget = 60;
    while (!ok && budget > 0) begin
      @(negedge clk);
      if (in_ready[c]) ok = 1'b1;
      budget--;
    end
    @(posedge clk); #1;
    in_valid[c] = 1'b0;
  endtask

  task automatic wait_obs(input int n, output bit ok);
    int budget;
    budget = 100;
    while (obs_q.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    ok = (obs_q.size() >= n);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    clear_model();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 4'b0)  begin errors++; $display("FAIL reset_in_ready got %h want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 24'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    checks++; if (out_chan !== 3'h0)  begin errors++; $display("FAIL reset_out_chan got %h want 0", out_chan); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    in_valid = 4'hF;
    @(negedge clk);
    checks++; if (in_ready !== 4'b0)  begin errors++; $display("FAIL reset_no_grant got %h want 0", in_ready); end
    @(posedge clk); #1;
    in_valid = '0;
    clear_model();
    rst = 1'b0;
  endtask

  task automatic test_single_channel();
    int  vals [5] = '{100, 200, 300, 400, 500};
    int  want [5] = '{25, 75, 150, 250, 350};
    bit  ok;
    rec_t o, e;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(0, vals[i], ok);
      checks++; if (!ok) begin errors++; $display("FAIL single_grant[%0d] got none want grant", i); end
      wait_obs(1, ok);
      checks++;
      if (!ok || exp_q.size() == 0) begin
        errors++; $display("FAIL single_out_timeout[%0d] got %0d outputs want 1", i, obs_q.size());
      end else begin
        o = obs_q.pop_front();
        e = exp_q.pop_front();
        checks++; if (o.data !== e.data)  begin errors++; $display("FAIL single_model[%0d] got %0d want %0d", i, o.data, e.data); end
        checks++; if (o.data !== want[i]) begin errors++; $display("FAIL single_value[%0d] got %0d want %0d", i, o.data, want[i]); end
        checks++; if (o.chan !== 0)       begin errors++; $display("FAIL single_chan[%0d] got %0d want 0", i, o.chan); end
        checks++; if (o.cyc - e.cyc !== 5) begin errors++; $display("FAIL single_latency[%0d] got %0d want 5", i, o.cyc - e.cyc); end
      end
    end
  endtask

  task automatic test_round_robin();
    int  want_ch  [5] = '{0, 1, 2, 3, 0};
    int  want_val [5] = '{250, 500, 750, 1000, 500};
    int  budget;
    bit  ok;
    rec_t o, e;
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < N_CH; k++) in_data[16*k +: 16] = 16'(1000 * (k + 1));
    in_valid = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    clear_model();
    rst = 1'b0;
    budget = 200;
    while (gnt_ch_q.size() < 5 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    @(posedge clk); #1;
    in_valid = '0;
    checks++;
    if (gnt_ch_q.size() < 5) begin
      errors++; $display("FAIL rr_grants got %0d grants want 5", gnt_ch_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (gnt_ch_q[i] !== want_ch[i]) begin errors++; $display("FAIL rr_order[%0d] got %0d want %0d", i, gnt_ch_q[i], want_ch[i]); end
      end
      for (int i = 1; i < 5; i++) begin
        checks++; if (gnt_cyc_q[i] - gnt_cyc_q[i-1] !== 6) begin errors++; $display("FAIL rr_spacing[%0d] got %0d want 6", i, gnt_cyc_q[i] - gnt_cyc_q[i-1]); end
      end
    end
    wait_obs(5, ok);
    checks++;
    if (!ok || exp_q.size() < 5) begin
      errors++; $display("FAIL rr_out_timeout got %0d outputs want 5", obs_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        o = obs_q.pop_front();
        e = exp_q.pop_front();
        checks++; if (o.data !== want_val[i]) begin errors++; $display("FAIL rr_value[%0d] got %0d want %0d", i, o.data, want_val[i]); end
        checks++; if (o.data !== e.data)      begin errors++; $display("FAIL rr_model[%0d] got %0d want %0d", i, o.data, e.data); end
        checks++; if (o.chan !== want_ch[i])  begin errors++; $display("FAIL rr_chan[%0d] got %0d want %0d", i, o.chan, want_ch[i]); end
      end
    end
    gnt_ch_q.delete();
    gnt_cyc_q.delete();
  endtask

  task automatic test_backpressure();
    bit   ok;
    int   budget;
    int   held;
    rec_t o, e;
    out_ready = 1'b0;
    send(2, 800, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_grant got none want grant"); end
    in_valid[1] = 1'b1;
    in_data[16 +: 16] = 16'(7);
    budget = 20;
    while (!out_valid && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    held = (exp_q.size() > 0) ? exp_q[0].data : 950;
    checks++; if (held !== 950) begin errors++; $display("FAIL bp_expected got %0d want 950", held); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (out_valid !== 1'b1 || int'(out_data) !== held || out_chan !== 3'd2 || in_ready !== 4'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d] got v=%b d=%0d c=%0d rdy=%h want v=1 d=%0d c=2 rdy=0",
                 i, out_valid, out_data, out_chan, in_ready, held);
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0)     begin errors++; $display("FAIL bp_release_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 4'b0010)   begin errors++; $display("FAIL bp_next_grant got %b want 0010", in_ready); end
    checks++; if (obs_q.size() !== 1)     begin errors++; $display("FAIL bp_handshakes got %0d want 1", obs_q.size()); end
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    wait_obs(2, ok);
    checks++;
    if (!ok || exp_q.size() < 2) begin
      errors++; $display("FAIL bp_out_timeout got %0d outputs want 2", obs_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        o = obs_q.pop_front();
        e = exp_q.pop_front();
        checks++; if (o.data !== e.data || o.chan !== e.chan) begin
          errors++; $display("FAIL bp_result[%0d] got %0d/ch%0d want %0d/ch%0d", i, o.data, o.chan, e.data, e.chan);
        end
      end
    end
  endtask

  task automatic test_sign();
    int   chs  [6] = '{1, 2, 3, 3, 3, 3};
    int   vals [6] = '{-4, 2, -32768, -32768, -32768, -32768};
`ifdef FIR_AVG_SCHED_ROUND_EN
    int   want [6] = '{-1, 1, -8192, -16384, -24576, -32768};
`else
    int   want [6] = '{-1, 0, -8192, -16384, -24576, -32768};
`endif
    bit   ok;
    rec_t o, e;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(chs[i], vals[i], ok);
      wait_obs(1, ok);
      checks++;
      if (!ok || exp_q.size() == 0) begin
        errors++; $display("FAIL sign_timeout[%0d] got %0d outputs want 1", i, obs_q.size());
      end else begin
        o = obs_q.pop_front();
        e = exp_q.pop_front();
        checks++; if (o.data !== want[i]) begin errors++; $display("FAIL sign_value[%0d] got %0d want %0d", i, o.data, want[i]); end
        checks++; if (o.data !== e.data)  begin errors++; $display("FAIL sign_model[%0d] got %0d want %0d", i, o.data, e.data); end
        checks++; if (o.chan !== chs[i])  begin errors++; $display("FAIL sign_chan[%0d] got %0d want %0d", i, o.chan, chs[i]); end
        if (i == 0) begin
          checks++; if (o.raw !== 24'hFFFFFF) begin errors++; $display("FAIL sign_raw got %h want ffffff", o.raw); end
        end
      end
    end
  endtask

  task automatic test_reset_mid_mac();
    bit   ok;
    rec_t o;
    out_ready = 1'b1;
    send(0, 800, ok);
    wait_obs(1, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL rmid_warm_timeout got %0d outputs want 1", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      void'(exp_q.pop_front());
      checks++; if (o.data !== 200) begin errors++; $display("FAIL rmid_warm got %0d want 200", o.data); end
    end
    send(0, 1234, ok);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy got %b want 1", busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 24'h0 || out_chan !== 3'h0 || busy !== 1'b0 || in_ready !== 4'b0) begin
      errors++;
      $display("FAIL rmid_reset got v=%b d=%h c=%0d busy=%b rdy=%h want all 0", out_valid, out_data, out_chan, busy, in_ready);
    end
    clear_model();
    rst = 1'b0;
    repeat (10) @(posedge clk);
    checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL rmid_ghost got %0d outputs want 0", obs_q.size()); end
    send(0, 400, ok);
    wait_obs(1, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL rmid_cold_timeout got %0d outputs want 1", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      void'(exp_q.pop_front());
      checks++; if (o.data !== 100) begin errors++; $display("FAIL rmid_cold got %0d want 100", o.data); end
      checks++; if (o.chan !== 0)   begin errors++; $display("FAIL rmid_cold_chan got %0d want 0", o.chan); end
    end
  endtask

  task automatic test_protocol();
    repeat (2) @(posedge clk);
    checks++; if (multi_gnt !== 0)     begin errors++; $display("FAIL proto_onehot got %0d multi-grants want 0", multi_gnt); end
    checks++; if (exp_q.size() !== 0)  begin errors++; $display("FAIL proto_leftover got %0d pending want 0", exp_q.size()); end
    checks++; if (obs_q.size() !== 0)  begin errors++; $display("FAIL proto_extra got %0d unexpected want 0", obs_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_round_robin();
    test_backpressure();
    test_sign();
    test_reset_mid_mac();
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
